// File: rtl/rupt_priority_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : rupt_priority_sched_if
// Description : RUPT request / vector bus between the sequencer and the rest
//               of the CPU.
// Revision    : 1.0  initial release
// ============================================================================
interface rupt_priority_sched_if #(
   parameter int NRUPT = 10,
   parameter int NW    = $clog2(NRUPT + 1)
);
   logic [NRUPT-1:0] rqst;
   logic             inhint;
   logic             ovf_;
   logic             nisq;
   logic             resume;
   logic             gojam;
   logic [NRUPT-1:0] pend;
   logic             rupt;
   logic [11:0]      rptadr;
   logic [NW-1:0]    rptnum;
   logic [NRUPT-1:0] rstrq;
   logic             inrupt;

   modport master (
      output rqst, inhint, ovf_, nisq, resume, gojam,
      input  pend, rupt, rptadr, rptnum, rstrq, inrupt
   );

   modport slave (
      input  rqst, inhint, ovf_, nisq, resume, gojam,
      output pend, rupt, rptadr, rptnum, rstrq, inrupt
   );
endinterface
`default_nettype wire

// File: rtl/rupt_priority_sched.sv
`default_nettype none
// ============================================================================
// Module      : rupt_priority_sched
// Description : Interrupt request latch, fixed-priority scheduler and vector
//               sequencer (IDLE / ARMED / TAKE / SERVICE).
// Revision    : 1.0  initial release
// ============================================================================
module rupt_priority_sched #(
   parameter int          NRUPT = 10,
   parameter logic [11:0] VBASE = 12'o4000
) (
   input  logic                 clk,
   input  logic                 rst,
   rupt_priority_sched_if.slave bus
);

   localparam int c_nw = $clog2(NRUPT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      TAKE    = 2'd2,
      SERVICE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [NRUPT-1:0] r_rqstd;
   logic [NRUPT-1:0] r_pend;
   logic             r_rupt;
   logic [NRUPT-1:0] r_rstrq;
   logic [11:0]      r_rptadr;
   logic [c_nw-1:0]  r_rptnum;
   logic             r_inrupt;

   logic             w_reset;
   logic [NRUPT-1:0] w_edge;
   logic [NRUPT-1:0] w_pend_nxt;
   logic             w_elig;
   logic [c_nw-1:0]  w_win;
   logic [NRUPT-1:0] w_sel;
   logic [c_nw-1:0]  w_num;
   logic [11:0]      w_vec;

   logic             w_rupt_nxt;
   logic [NRUPT-1:0] w_rstrq_nxt;
   logic [11:0]      w_rptadr_nxt;
   logic [c_nw-1:0]  w_rptnum_nxt;
   logic             w_inrupt_nxt;

   assign w_reset = rst | bus.gojam;
   assign w_edge  = bus.rqst & ~r_rqstd;

   // r_rstrq is nonzero only during TAKE, so it doubles as the clear mask;
   // OR-ing the edge last lets a coincident new request survive the clear.
   assign w_pend_nxt = (r_pend & ~r_rstrq) | w_edge;

   assign w_elig = (|r_pend) & ~bus.inhint & bus.ovf_;

   // Lowest set index wins; w_sel is the matching one-hot.
   always_comb begin
      w_win = '0;
      for (int k = NRUPT - 1; k >= 0; k--) begin
         if (r_pend[k]) begin
            w_win = c_nw'(k);
         end
      end
   end

   assign w_sel = r_pend & (~r_pend + NRUPT'(1));
   assign w_num = w_win + c_nw'(1);
   assign w_vec = VBASE + (12'(w_num) << 2);

   always_ff @(posedge clk) begin
      if (w_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_rupt_nxt   = 1'b0;
      w_rstrq_nxt  = '0;
      w_rptadr_nxt = r_rptadr;
      w_rptnum_nxt = r_rptnum;
      case (r_state)
         IDLE: begin
            if (w_elig) begin
               w_state_nxt = ARMED;
            end
         end
         ARMED: begin
            // Losing eligibility outranks an instruction-boundary strobe.
            if (!w_elig) begin
               w_state_nxt = IDLE;
            end else if (bus.nisq) begin
               w_state_nxt  = TAKE;
               w_rupt_nxt   = 1'b1;
               w_rstrq_nxt  = w_sel;
               w_rptadr_nxt = w_vec;
               w_rptnum_nxt = w_num;
            end
         end
         TAKE: begin
            w_state_nxt = SERVICE;
         end
         SERVICE: begin
            if (bus.resume) begin
               w_state_nxt  = IDLE;
               w_rptadr_nxt = '0;
               w_rptnum_nxt = '0;
            end
         end
         default: begin
            w_state_nxt  = IDLE;
            w_rptadr_nxt = '0;
            w_rptnum_nxt = '0;
         end
      endcase
      w_inrupt_nxt = (w_state_nxt == TAKE) || (w_state_nxt == SERVICE);
   end

   always_ff @(posedge clk) begin
      if (w_reset) begin
         r_rqstd  <= '0;
         r_pend   <= '0;
         r_rupt   <= 1'b0;
         r_rstrq  <= '0;
         r_rptadr <= '0;
         r_rptnum <= '0;
         r_inrupt <= 1'b0;
      end else begin
         r_rqstd  <= bus.rqst;
         r_pend   <= w_pend_nxt;
         r_rupt   <= w_rupt_nxt;
         r_rstrq  <= w_rstrq_nxt;
         r_rptadr <= w_rptadr_nxt;
         r_rptnum <= w_rptnum_nxt;
         r_inrupt <= w_inrupt_nxt;
      end
   end

   assign bus.pend   = r_pend;
   assign bus.rupt   = r_rupt;
   assign bus.rstrq  = r_rstrq;
   assign bus.rptadr = r_rptadr;
   assign bus.rptnum = r_rptnum;
   assign bus.inrupt = r_inrupt;

endmodule
`default_nettype wire

// File: tb/tb_rupt_priority_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rupt_priority_sched
// Description : Directed bench; expected takes are queued as NISQ is driven
//               and popped whenever the DUT pulses RUPT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rupt_priority_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   rupt_priority_sched_if #(.NRUPT(10)) bus ();

   rupt_priority_sched #(.NRUPT(10), .VBASE(12'o4000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [11:0] adr;
      logic [3:0]  num;
      logic [9:0]  rq;
   } exp_t;

   exp_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one NISQ strobe from ARMED and record the take it must produce.
   task automatic take(input logic [11:0] adr, input logic [3:0] num, input logic [9:0] rq);
      exp_t e;
      e.adr = adr;
      e.num = num;
      e.rq  = rq;
      sb.push_back(e);
      bus.nisq = 1'b1;
      tick();
      bus.nisq = 1'b0;
   endtask

   task automatic do_resume();
      bus.resume = 1'b1;
      tick();
      bus.resume = 1'b0;
   endtask

   always @(negedge clk) begin
      if (bus.rupt === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_rupt", 32'(bus.rptadr), 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("take_rptadr", 32'(bus.rptadr), 32'(e.adr));
            check("take_rptnum", 32'(bus.rptnum), 32'(e.num));
            check("take_rstrq",  32'(bus.rstrq),  32'(e.rq));
            check("take_inrupt", 32'(bus.inrupt), 32'h1);
         end
      end
   end

   initial begin
      bus.rqst   = '0;
      bus.inhint = 1'b0;
      bus.ovf_   = 1'b1;
      bus.nisq   = 1'b0;
      bus.resume = 1'b0;
      bus.gojam  = 1'b0;
      tick(3);
      check("rst_pend",   32'(bus.pend),   32'h0);
      check("rst_rupt",   32'(bus.rupt),   32'h0);
      check("rst_rptadr", 32'(bus.rptadr), 32'h0);
      check("rst_rptnum", 32'(bus.rptnum), 32'h0);
      check("rst_rstrq",  32'(bus.rstrq),  32'h0);
      check("rst_inrupt", 32'(bus.inrupt), 32'h0);
      rst = 1'b0;
      tick();

      // Single source, KYRPT1
      bus.rqst[4] = 1'b1;
      tick();
      bus.rqst[4] = 1'b0;
      check("t1_pend_set", 32'(bus.pend), 32'h010);
      tick();
      take(12'o4024, 4'd5, 10'b0000010000);
      check("t1_pend_in_take", 32'(bus.pend), 32'h010);
      tick();
      check("t1_pend_cleared", 32'(bus.pend),   32'h0);
      check("t1_rupt_dropped", 32'(bus.rupt),   32'h0);
      check("t1_svc_rptadr",   32'(bus.rptadr), 32'(12'o4024));
      check("t1_svc_rptnum",   32'(bus.rptnum), 32'd5);
      tick(3);
      check("t1_svc_inrupt",   32'(bus.inrupt), 32'h1);
      do_resume();
      check("t1_idle_inrupt",  32'(bus.inrupt), 32'h0);
      check("t1_idle_rptadr",  32'(bus.rptadr), 32'h0);
      check("t1_idle_rptnum",  32'(bus.rptnum), 32'h0);

      // Priority: DNRUPT and T6RUPT together
      bus.rqst[7] = 1'b1;
      bus.rqst[0] = 1'b1;
      tick();
      bus.rqst = '0;
      check("t2_pend_both", 32'(bus.pend), 32'h081);
      tick();
      take(12'o4004, 4'd1, 10'h001);
      tick();
      check("t2_pend_left", 32'(bus.pend), 32'h080);
      do_resume();
      tick();
      take(12'o4040, 4'd8, 10'h080);
      tick();
      check("t2_second_num", 32'(bus.rptnum), 32'd8);
      check("t2_pend_empty", 32'(bus.pend),   32'h0);
      do_resume();

      // Inhibit by INHINT
      bus.inhint = 1'b1;
      bus.rqst[2] = 1'b1;
      tick();
      bus.rqst[2] = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.nisq = 1'b1;
         tick();
         bus.nisq = 1'b0;
         tick();
      end
      check("t3_inhint_pend",   32'(bus.pend),   32'h004);
      check("t3_inhint_inrupt", 32'(bus.inrupt), 32'h0);
      bus.inhint = 1'b0;
      tick();
      take(12'o4014, 4'd3, 10'h004);
      tick();
      check("t3_inhint_adr", 32'(bus.rptadr), 32'(12'o4014));
      do_resume();

      // Overflow dropping in ARMED, coincident with NISQ
      bus.rqst[2] = 1'b1;
      tick();
      bus.rqst[2] = 1'b0;
      tick();
      bus.ovf_ = 1'b0;
      bus.nisq = 1'b1;
      tick();
      bus.nisq = 1'b0;
      tick();
      bus.nisq = 1'b1;
      tick();
      bus.nisq = 1'b0;
      tick();
      check("t3_ovf_pend",   32'(bus.pend),   32'h004);
      check("t3_ovf_inrupt", 32'(bus.inrupt), 32'h0);
      bus.ovf_ = 1'b1;
      tick();
      take(12'o4014, 4'd3, 10'h004);
      tick();
      check("t3_ovf_adr", 32'(bus.rptadr), 32'(12'o4014));
      do_resume();

      // No nesting during T4 service
      bus.rqst[3] = 1'b1;
      tick();
      bus.rqst[3] = 1'b0;
      tick();
      take(12'o4020, 4'd4, 10'h008);
      tick();
      bus.rqst[0] = 1'b1;
      tick();
      bus.rqst[0] = 1'b0;
      check("t4_pend_t6", 32'(bus.pend), 32'h001);
      bus.nisq = 1'b1;
      tick();
      bus.nisq = 1'b0;
      tick();
      check("t4_still_svc", 32'(bus.inrupt), 32'h1);
      check("t4_adr_held",  32'(bus.rptadr), 32'(12'o4020));
      do_resume();
      tick();
      take(12'o4004, 4'd1, 10'h001);
      tick();
      do_resume();

      // Set/clear collision on KYRPT2
      bus.rqst[5] = 1'b1;
      tick();
      bus.rqst[5] = 1'b0;
      tick();
      take(12'o4030, 4'd6, 10'h020);
      bus.rqst[5] = 1'b1;
      tick();
      bus.rqst[5] = 1'b0;
      check("t5_set_wins", 32'(bus.pend), 32'h020);
      do_resume();
      tick();
      take(12'o4030, 4'd6, 10'h020);
      tick();
      check("t5_pend_empty", 32'(bus.pend), 32'h0);
      do_resume();

      // Held level gives one edge; re-raise re-pends
      bus.rqst[1] = 1'b1;
      tick();
      check("t6_level_pend", 32'(bus.pend), 32'h002);
      tick();
      take(12'o4010, 4'd2, 10'h002);
      tick(3);
      check("t6_no_second_edge", 32'(bus.pend), 32'h0);
      bus.rqst[1] = 1'b0;
      do_resume();
      bus.rqst[1] = 1'b1;
      tick();
      bus.rqst[1] = 1'b0;
      check("t6_repend", 32'(bus.pend), 32'h002);
      tick();
      take(12'o4010, 4'd2, 10'h002);
      tick();
      do_resume();

      // GOJAM mid-service with two pending requests
      bus.rqst[2] = 1'b1;
      tick();
      bus.rqst[2] = 1'b0;
      tick();
      take(12'o4014, 4'd3, 10'h004);
      tick();
      bus.rqst[1:0] = 2'b11;
      tick();
      bus.rqst[1:0] = 2'b00;
      check("t7_pend_pre", 32'(bus.pend), 32'h003);
      bus.gojam   = 1'b1;
      bus.rqst[9] = 1'b1;
      tick();
      bus.gojam = 1'b0;
      check("t7_gj_pend",   32'(bus.pend),   32'h0);
      check("t7_gj_rupt",   32'(bus.rupt),   32'h0);
      check("t7_gj_rptadr", 32'(bus.rptadr), 32'h0);
      check("t7_gj_rptnum", 32'(bus.rptnum), 32'h0);
      check("t7_gj_rstrq",  32'(bus.rstrq),  32'h0);
      check("t7_gj_inrupt", 32'(bus.inrupt), 32'h0);
      tick();
      check("t7_held_edge", 32'(bus.pend), 32'h200);
      bus.rqst[9] = 1'b0;
      tick();
      take(12'o4050, 4'd10, 10'h200);
      tick();
      do_resume();

      tick(3);
      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
